// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer between the MAC RX stream and the DMA core.
// Frames are written into a circular buffer and become visible to the reader only
// once their last beat has arrived clean. Bad, overflowing and oversize frames are
// rewound away and counted. Single clock, synchronous active-high reset.
module eth_rx_frame_fifo #(
    parameter int ADDR_BITS = 9,
    parameter int MAX_BEATS = 190,
    parameter int CNT_BITS  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 link_up,
    input  logic [63:0]          s_axis_tdata,
    input  logic [7:0]           s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic [7:0]           m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic                 counters_clear,
    output logic [CNT_BITS-1:0]  frames_ok,
    output logic [CNT_BITS-1:0]  frames_bad,
    output logic [CNT_BITS-1:0]  frames_overflow,
    output logic [CNT_BITS-1:0]  frames_oversize,
    output logic [ADDR_BITS:0]   fill_level
);

    localparam int PTR_W  = ADDR_BITS + 1;
    localparam int BCNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [PTR_W-1:0]    DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [BCNT_W-1:0]   MAX_CNT = BCNT_W'(MAX_BEATS);
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_STORE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_BITS'(1);
        end
    endfunction

    state_t              state_r, state_n_s;
    logic [PTR_W-1:0]    wr_ptr_r, wr_ptr_n_s;
    logic [PTR_W-1:0]    commit_ptr_r, commit_ptr_n_s;
    logic [PTR_W-1:0]    rd_ptr_r, rd_ptr_n_s;
    logic [BCNT_W-1:0]   beat_cnt_r, beat_cnt_n_s;
    logic                cause_ovf_r, cause_ovf_n_s;   // 1: drop due to overflow, 0: oversize
    logic                wr_en_s;
    logic                inc_ok_s, inc_bad_s, inc_ovf_s, inc_osz_s;
    logic                beat_s, full_s, avail_s;
    logic                rd_en_s, load_out_s;
    logic [72:0]         mem_r [0:(1 << ADDR_BITS) - 1];
    logic [72:0]         rd_data_r;
    logic                rd_vld_r;

    assign beat_s     = s_axis_tvalid & s_axis_tready;
    assign full_s     = ((wr_ptr_r - rd_ptr_r) == DEPTH);
    assign avail_s    = (rd_ptr_r != commit_ptr_r);
    assign load_out_s = rd_vld_r & (~m_axis_tvalid | m_axis_tready);
    assign rd_en_s    = avail_s & (~rd_vld_r | load_out_s);
    assign rd_ptr_n_s = rd_ptr_r + PTR_W'(rd_en_s);

    // Input-side next state: where each accepted beat goes and which counter it bumps.
    always_comb begin
        state_n_s      = state_r;
        wr_ptr_n_s     = wr_ptr_r;
        commit_ptr_n_s = commit_ptr_r;
        beat_cnt_n_s   = beat_cnt_r;
        cause_ovf_n_s  = cause_ovf_r;
        wr_en_s        = 1'b0;
        inc_ok_s       = 1'b0;
        inc_bad_s      = 1'b0;
        inc_ovf_s      = 1'b0;
        inc_osz_s      = 1'b0;
        if (!link_up) begin
            // Losing the link abandons any partial frame silently.
            state_n_s    = ST_SYNC;
            wr_ptr_n_s   = commit_ptr_r;
            beat_cnt_n_s = '0;
        end else begin
            case (state_r)
                ST_SYNC: begin
                    if (beat_s && s_axis_tlast) begin
                        state_n_s = ST_STORE;
                    end else begin
                        state_n_s = ST_SYNC;
                    end
                end
                ST_STORE: begin
                    if (beat_s && s_axis_tlast) begin
                        beat_cnt_n_s = '0;
                        if (full_s) begin
                            wr_ptr_n_s = commit_ptr_r;
                            inc_ovf_s  = 1'b1;
                        end else if (beat_cnt_r == MAX_CNT) begin
                            // Last beat would make the frame one beat too long.
                            wr_ptr_n_s = commit_ptr_r;
                            inc_osz_s  = 1'b1;
                        end else if (s_axis_tuser) begin
                            wr_ptr_n_s = commit_ptr_r;
                            inc_bad_s  = 1'b1;
                        end else begin
                            wr_en_s        = 1'b1;
                            wr_ptr_n_s     = wr_ptr_r + PTR_W'(1);
                            commit_ptr_n_s = wr_ptr_r + PTR_W'(1);
                            inc_ok_s       = 1'b1;
                        end
                    end else if (beat_s) begin
                        if (full_s) begin
                            wr_ptr_n_s    = commit_ptr_r;
                            beat_cnt_n_s  = '0;
                            cause_ovf_n_s = 1'b1;
                            state_n_s     = ST_DROP;
                        end else if (beat_cnt_r == MAX_CNT) begin
                            wr_ptr_n_s    = commit_ptr_r;
                            beat_cnt_n_s  = '0;
                            cause_ovf_n_s = 1'b0;
                            state_n_s     = ST_DROP;
                        end else begin
                            wr_en_s      = 1'b1;
                            wr_ptr_n_s   = wr_ptr_r + PTR_W'(1);
                            beat_cnt_n_s = beat_cnt_r + BCNT_W'(1);
                        end
                    end else begin
                        state_n_s = ST_STORE;
                    end
                end
                ST_DROP: begin
                    if (beat_s && s_axis_tlast) begin
                        inc_ovf_s = cause_ovf_r;
                        inc_osz_s = ~cause_ovf_r;
                        state_n_s = ST_STORE;
                    end else begin
                        state_n_s = ST_DROP;
                    end
                end
                default: begin
                    state_n_s = ST_SYNC;
                end
            endcase
        end
    end

    // Input-side state, pointers and the always-ready flag toward the MAC.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_SYNC;
            wr_ptr_r      <= '0;
            commit_ptr_r  <= '0;
            rd_ptr_r      <= '0;
            beat_cnt_r    <= '0;
            cause_ovf_r   <= 1'b0;
            s_axis_tready <= 1'b0;
            fill_level    <= '0;
        end else begin
            state_r       <= state_n_s;
            wr_ptr_r      <= wr_ptr_n_s;
            commit_ptr_r  <= commit_ptr_n_s;
            rd_ptr_r      <= rd_ptr_n_s;
            beat_cnt_r    <= beat_cnt_n_s;
            cause_ovf_r   <= cause_ovf_n_s;
            s_axis_tready <= 1'b1;
            fill_level    <= wr_ptr_n_s - rd_ptr_n_s;
        end
    end

    // Frame storage write port; contents need no reset since pointers gate visibility.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[ADDR_BITS-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Synchronous read stage; its register doubles as the skid slot under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_r <= '0;
            rd_vld_r  <= 1'b0;
        end else if (rd_en_s) begin
            rd_data_r <= mem_r[rd_ptr_r[ADDR_BITS-1:0]];
            rd_vld_r  <= 1'b1;
        end else if (load_out_s) begin
            rd_vld_r  <= 1'b0;
        end
    end

    // Output register toward the DMA core; holds steady while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (load_out_s) begin
            m_axis_tdata  <= rd_data_r[63:0];
            m_axis_tkeep  <= rd_data_r[71:64];
            m_axis_tlast  <= rd_data_r[72];
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Statistics counters; a clear pulse beats any same-cycle increment.
    always_ff @(posedge clock) begin
        if (reset || counters_clear) begin
            frames_ok       <= '0;
            frames_bad      <= '0;
            frames_overflow <= '0;
            frames_oversize <= '0;
        end else begin
            if (inc_ok_s)  frames_ok       <= sat_inc(frames_ok);
            if (inc_bad_s) frames_bad      <= sat_inc(frames_bad);
            if (inc_ovf_s) frames_overflow <= sat_inc(frames_overflow);
            if (inc_osz_s) frames_oversize <= sat_inc(frames_oversize);
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Self-checking bench for eth_rx_frame_fifo: random frames through a small buffer,
// checked against a frame-level reference model (expected beat queue + counts).
module tb_eth_rx_frame_fifo;

    localparam int AB   = 4;
    localparam int MAXB = 12;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset, link_up;
    logic [63:0]   s_tdata;
    logic [7:0]    s_tkeep;
    logic          s_tlast, s_tuser, s_tvalid, s_tready;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tlast, m_tvalid, m_tready;
    logic          counters_clear;
    logic [CW-1:0] f_ok, f_bad, f_ovf, f_osz;
    logic [AB:0]   fill;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [72:0] exp_q[$];
    int  e_ok = 0, e_bad = 0, e_ovf = 0, e_osz = 0;
    bit  synced = 1'b0;
    int  extra = 0;
    int  rdy_mode = 0;          // 0: always ready, 1: never ready, 2: random
    bit  hold_pend = 1'b0;
    logic [72:0] held, mon_beat, exp_beat;

    eth_rx_frame_fifo #(.ADDR_BITS(AB), .MAX_BEATS(MAXB), .CNT_BITS(CW)) dut (
        .clock(clock), .reset(reset), .link_up(link_up),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .counters_clear(counters_clear),
        .frames_ok(f_ok), .frames_bad(f_bad), .frames_overflow(f_ovf),
        .frames_oversize(f_osz), .fill_level(fill)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Downstream ready pattern, changed just after each rising edge.
    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'b0;
            default: m_tready = (($urandom % 3) != 0);
        endcase
    end

    // Output monitor: scoreboard on handshakes, stability while stalled.
    always @(negedge clock) begin
        mon_beat = {m_tlast, m_tkeep, m_tdata};
        if (hold_pend) begin
            check_eq("hold_valid", {79'd0, m_tvalid}, 80'd1);
            check_eq("hold_data", {7'd0, mon_beat}, {7'd0, held});
        end
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                extra++;
            end else begin
                exp_beat = exp_q.pop_front();
                check_eq("out_beat", {7'd0, mon_beat}, {7'd0, exp_beat});
            end
        end
        hold_pend = m_tvalid && !m_tready;
        held      = mon_beat;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_ok"},  80'(f_ok),  80'(sat(e_ok)));
        check_eq({tag, "_bad"}, 80'(f_bad), 80'(sat(e_bad)));
        check_eq({tag, "_ovf"}, 80'(f_ovf), 80'(sat(e_ovf)));
        check_eq({tag, "_osz"}, 80'(f_osz), 80'(sat(e_osz)));
    endtask

    // Send one frame; the model decides its fate from the frame-level rules.
    task automatic send_frame(input int len, input bit user, input bit exp_ovf, input bit clr_last);
        logic [72:0] beats[$];
        logic [63:0] d;
        logic [7:0]  k;
        for (int i = 0; i < len; i++) begin
            if (($urandom % 4) == 0) begin
                s_tvalid = 1'b0;
                counters_clear = 1'b0;
                tick();
            end
            d = {$urandom, $urandom};
            k = 8'($urandom);
            s_tdata  = d;
            s_tkeep  = k;
            s_tlast  = (i == len - 1);
            s_tuser  = (i == len - 1) ? user : 1'($urandom);
            s_tvalid = 1'b1;
            counters_clear = clr_last && (i == len - 1);
            beats.push_back({s_tlast, k, d});
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        counters_clear = 1'b0;
        if (!synced) begin
            synced = 1'b1;
        end else if (exp_ovf) begin
            e_ovf++;
        end else if (len > MAXB) begin
            e_osz++;
        end else if (user) begin
            e_bad++;
        end else begin
            e_ok++;
            foreach (beats[j]) exp_q.push_back(beats[j]);
        end
        if (clr_last) begin
            e_ok = 0; e_bad = 0; e_ovf = 0; e_osz = 0;
        end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            s_tdata  = {$urandom, $urandom};
            s_tkeep  = 8'($urandom);
            s_tlast  = 1'b0;
            s_tuser  = 1'b0;
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_pending(input int limit);
        int n = 0;
        while (exp_q.size() > limit && n < 3000) begin
            tick();
            n++;
        end
        if (exp_q.size() > limit) check_eq("pend_timeout", 80'(exp_q.size()), 80'(limit));
    endtask

    task automatic drain_check(input string tag);
        wait_pending(0);
        repeat (4) tick();
        check_eq({tag, "_extra"}, 80'(extra), 80'd0);
        check_eq({tag, "_fill"}, 80'(fill), 80'd0);
        check_counters(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit user;
        reset = 1'b1; link_up = 1'b1; counters_clear = 1'b0;
        s_tdata = 64'd0; s_tkeep = 8'd0; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) tick();
        check_eq("rst_s_tready", 80'(s_tready), 80'd0);
        check_eq("rst_m_tvalid", 80'(m_tvalid), 80'd0);
        check_eq("rst_m_data", {7'd0, m_tlast, m_tkeep, m_tdata}, 80'd0);
        check_eq("rst_fill", 80'(fill), 80'd0);
        check_counters("rst");
        reset = 1'b0;
        tick();
        check_eq("tready_up", 80'(s_tready), 80'd1);

        // 1: sync on an idle tlast beat, then an 8-beat frame with latency check
        send_frame(1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        send_frame(8, 1'b0, 1'b0, 1'b0);
        check_eq("lat_c0", 80'(m_tvalid), 80'd0);
        tick();
        check_eq("lat_c1", 80'(m_tvalid), 80'd0);
        tick();
        check_eq("lat_c2", 80'(m_tvalid), 80'd1);
        drain_check("t1");

        // 2: bad frame dropped, good frame passes
        send_frame(8, 1'b1, 1'b0, 1'b0);
        send_frame(3, 1'b0, 1'b0, 1'b0);
        drain_check("t2");

        // 3: buffer fills while downstream stalls; second frame overflows
        rdy_mode = 1;
        repeat (2) tick();
        send_frame(10, 1'b0, 1'b0, 1'b0);
        send_frame(10, 1'b0, 1'b1, 1'b0);
        check_counters("t3_stall");
        repeat (5) tick();
        rdy_mode = 0;
        drain_check("t3");

        // 4: oversize frame dropped; max-length and single-beat frames pass
        send_frame(MAXB + 2, 1'b0, 1'b0, 1'b0);
        send_frame(MAXB, 1'b0, 1'b0, 1'b0);
        send_frame(1, 1'b0, 1'b0, 1'b0);
        drain_check("t4");

        // 5: link drop mid-frame under random backpressure
        rdy_mode = 2;
        send_frame(5, 1'b0, 1'b0, 1'b0);
        send_partial(3);
        link_up = 1'b0;
        synced  = 1'b0;
        repeat (3) tick();
        link_up = 1'b1;
        tick();
        send_frame(1, 1'b0, 1'b0, 1'b0);
        send_frame(6, 1'b0, 1'b0, 1'b0);
        drain_check("t5");

        // Random traffic
        for (int f = 0; f < 60; f++) begin
            if (($urandom % 8) == 0) len = MAXB + 2 + int'($urandom % 3);
            else len = 1 + int'($urandom % MAXB);
            user = (($urandom % 5) == 0);
            wait_pending((len > MAXB) ? 0 : 4);
            send_frame(len, user, 1'b0, 1'b0);
            check_counters("rnd");
            repeat ($urandom % 3) tick();
        end
        drain_check("rnd_end");

        // 6: saturation, then clear colliding with an increment
        rdy_mode = 0;
        while (e_ok < CMAX + 2) begin
            wait_pending(4);
            send_frame(1, 1'b0, 1'b0, 1'b0);
        end
        check_eq("sat_ok", 80'(f_ok), 80'(CMAX));
        send_frame(2, 1'b0, 1'b0, 1'b1);
        check_counters("clr");
        send_frame(2, 1'b0, 1'b0, 1'b0);
        drain_check("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
